uart_rx_param: RTL and testbench

- Parametrised UART receiver. Successor to the fixed 8-bit/odd-parity receiver path.
- Adds a configurable baud divisor, data width, parity mode and stop-bit count.
- Adds a holding register with a valid/ready handshake and per-frame error flags.
- Sits between the async serial pin and the host-side consumer (FIFO or register bank).

---
 rtl/uart_rx_param.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
// A 2-flop synchroniser feeds a bit-timed IDLE/START/DATA/PARITY/STOP/DONE FSM.
// Each completed frame goes into a valid/ready holding register with per-frame error flags.
// Optional feature macro: UART_RX_MAJORITY_EN. When it is defined, every bit is decided by
// a 2-of-3 vote over three adjacent samples. Otherwise a single mid-bit sample decides it.
module uart_rx_param #(
    parameter int CLK_DIV     = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 2,
    parameter int STOP_BITS   = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 serial_data_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [3:0]    IDX_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    IDX_STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // 2-of-3 majority vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        maj3 = (a & b) | (a & c) | (b & c);
    endfunction

    // Parity error for a received word and its parity bit under the configured mode
    function automatic logic parity_error(input logic [DATA_BITS-1:0] data, input logic pbit);
        logic x;
        x = (^data) ^ pbit;
        case (PARITY_MODE)
            1:       parity_error = x;
            2:       parity_error = ~x;
            default: parity_error = 1'b0;
        endcase
    endfunction

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   pbit_q, pbit_d;
    logic                   ferr_q, ferr_d;
    logic                   sync1_q, sync2_q, line_prev_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rx_valid_q, parity_err_q, frame_err_q, overrun_q, busy_q;
    logic                   line_s, fall_s, sample_s;

    assign line_s = sync2_q;
    assign fall_s = line_prev_q & ~line_s;

`ifdef UART_RX_MAJORITY_EN
    // The vote takes three consecutive samples around the decision point. sync1_q is one
    // cycle ahead of the line and line_prev_q is one cycle behind it. This keeps the
    // decision cycle, and therefore the latency, the same as the single-sample build.
    assign sample_s = maj3(line_prev_q, line_s, sync1_q);
`else
    assign sample_s = line_s;
`endif

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

    // Synchronise the serial pin and keep the previous line value for edge detection
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= serial_data_in;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
        end
    end

    // Next-state logic for the frame FSM, the bit timer and the sampling datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        idx_d   = idx_q;
        shift_d = shift_q;
        pbit_d  = pbit_q;
        ferr_d  = ferr_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                idx_d = 4'd0;
                if (fall_s) begin
                    state_d = ST_START;
                    ferr_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = CNT_ZERO;
                    if (sample_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    shift_d = {sample_s, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_DATA_LAST) begin
                        idx_d   = 4'd0;
                        state_d = (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    pbit_d  = sample_s;
                    idx_d   = 4'd0;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = CNT_ZERO;
                    // A low stop bit is remembered, and sampling still runs through every stop bit
                    if (!sample_s) begin
                        ferr_d = 1'b1;
                    end else begin
                        ferr_d = ferr_q;
                    end
                    if (idx_q == IDX_STOP_LAST) begin
                        idx_d   = 4'd0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_DONE: begin
                cnt_d   = CNT_ZERO;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = CNT_ZERO;
                idx_d   = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, bit timer and sampling datapath registers
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= 4'd0;
            shift_q <= {DATA_BITS{1'b0}};
            pbit_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            pbit_q  <= pbit_d;
            ferr_q  <= ferr_d;
        end
    end

    // Holding register: commit on DONE, drop with an overrun pulse if the held word is unaccepted
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rx_data_q    <= {DATA_BITS{1'b0}};
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            busy_q    <= (state_d != ST_IDLE);
            if (state_q == ST_DONE) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q    <= shift_q;
                    parity_err_q <= parity_error(shift_q, pbit_q);
                    frame_err_q  <= ferr_q;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end else begin
                rx_valid_q <= rx_valid_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param. Three instances (8N1, 8O1, 8N2, CLK_DIV=16) are checked
// against a frame-level model. Directed frames, with literal expectations, pin that model.
module tb_uart_rx_param;

    localparam int C = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser [3];
    logic       rdy [3];
    logic [7:0] rxd [3];
    logic       vld [3];
    logic       pe  [3];
    logic       fe  [3];
    logic       ov  [3];
    logic       bsy [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Pending frame per instance: written only by the stimulus side
    int pend_due [3];
    int pend_d   [3];
    int pend_p   [3];
    int pend_f   [3];
    int start_cyc[3];

    // Observation records: written only by the compare process
    int got_d [3];
    int got_p [3];
    int got_f [3];
    int frames[3];
    int ovr_seen[3];
    int rise_cyc[3];

    uart_rx_param #(.CLK_DIV(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_n1 (
        .sys_clk(clk), .rst(rst), .serial_data_in(ser[0]), .rx_data(rxd[0]), .rx_valid(vld[0]),
        .rx_ready(rdy[0]), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .busy(bsy[0]));
    uart_rx_param #(.CLK_DIV(C), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_o1 (
        .sys_clk(clk), .rst(rst), .serial_data_in(ser[1]), .rx_data(rxd[1]), .rx_valid(vld[1]),
        .rx_ready(rdy[1]), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]), .busy(bsy[1]));
    uart_rx_param #(.CLK_DIV(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_n2 (
        .sys_clk(clk), .rst(rst), .serial_data_in(ser[2]), .rx_data(rxd[2]), .rx_valid(vld[2]),
        .rx_ready(rdy[2]), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]), .busy(bsy[2]));

    always #5 clk = ~clk;

    // Cycle counter: number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pm_of(input int d);
        pm_of = (d == 1) ? 2 : 0;
    endfunction

    function automatic int sb_of(input int d);
        sb_of = (d == 2) ? 2 : 1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send one frame on instance d and tell the model what it must deliver, and when.
    // gbit is the wire-bit index that gets a one-cycle low glitch at mid-bit (-1 means none).
    // keep=1 leaves the line at the last bit level; otherwise it returns high.
    task automatic send_frame(input int d, input int dat, input int pbit, input int st1,
                              input int st2, input int gbit, input int keep);
        int bits[16];
        int nb;
        int ones;
        int perr;
        nb = 0;
        bits[nb] = 0; nb++;
        for (int k = 0; k < 8; k++) begin bits[nb] = (dat >> k) & 1; nb++; end
        if (pm_of(d) != 0) begin bits[nb] = pbit; nb++; end
        bits[nb] = st1; nb++;
        if (sb_of(d) == 2) begin bits[nb] = st2; nb++; end
        ones = pbit;
        for (int k = 0; k < 8; k++) ones += (dat >> k) & 1;
        if (pm_of(d) == 1) perr = ones % 2;
        else if (pm_of(d) == 2) perr = 1 - (ones % 2);
        else perr = 0;
        @(posedge clk); #1;
        start_cyc[d] = cyc;
        pend_d[d]    = dat & 255;
        pend_p[d]    = perr;
        pend_f[d]    = (st1 == 0 || (sb_of(d) == 2 && st2 == 0)) ? 1 : 0;
        // 2 sync + half bit + (data + parity + stop) bits + 2
        pend_due[d]  = cyc + 2 + C / 2 + (nb - 1) * C + 2;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < C; c++) begin
                if (b != 0 || c != 0) begin @(posedge clk); #1; end
                if (b == 1 && c == 0) chk($sformatf("busy_mid[%0d]", d), int'(bsy[d]), 1);
                ser[d] = (b == gbit && c == C / 2) ? 1'b0 : (bits[b] != 0);
            end
        end
        @(posedge clk); #1;
        chk($sformatf("busy_end[%0d]", d), int'(bsy[d]), 0);
        if (keep == 0) ser[d] = 1'b1;
    endtask

    // Frame-level model and per-cycle comparison of all three instances
    initial begin
        int mv[3];
        int md[3];
        int mp[3];
        int mf[3];
        int rdy_prev[3];
        int vld_prev[3];
        int vb;
        int eo;
        for (int i = 0; i < 3; i++) begin
            mv[i] = 0; md[i] = 0; mp[i] = 0; mf[i] = 0; rdy_prev[i] = 0; vld_prev[i] = 0;
            got_d[i] = 0; got_p[i] = 0; got_f[i] = 0; frames[i] = 0; ovr_seen[i] = 0; rise_cyc[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                eo = 0;
                if (rst) begin
                    mv[i] = 0;
                end else begin
                    vb = mv[i];
                    if (vb != 0 && rdy_prev[i] != 0) mv[i] = 0;
                    if (cyc == pend_due[i]) begin
                        if (vb != 0 && rdy_prev[i] == 0) begin
                            eo = 1;
                        end else begin
                            mv[i] = 1; md[i] = pend_d[i]; mp[i] = pend_p[i]; mf[i] = pend_f[i];
                        end
                    end
                end
                chk($sformatf("valid[%0d]", i), int'(vld[i]), mv[i]);
                chk($sformatf("overrun[%0d]", i), int'(ov[i]), eo);
                if (mv[i] != 0) begin
                    chk($sformatf("data[%0d]", i), int'(rxd[i]), md[i]);
                    chk($sformatf("perr[%0d]", i), int'(pe[i]), mp[i]);
                    chk($sformatf("ferr[%0d]", i), int'(fe[i]), mf[i]);
                end
                if (vld[i] && vld_prev[i] == 0) begin
                    rise_cyc[i] = cyc;
                    frames[i]++;
                end
                if (vld[i] && rdy[i]) begin
                    got_d[i] = int'(rxd[i]); got_p[i] = int'(pe[i]); got_f[i] = int'(fe[i]);
                end
                if (ov[i]) ovr_seen[i]++;
                rdy_prev[i] = int'(rdy[i]);
                vld_prev[i] = int'(vld[i]);
            end
        end
    end

    // Directed stimulus with literal expectations
    initial begin
        int f0;
        for (int i = 0; i < 3; i++) begin
            ser[i] = 1'b1; rdy[i] = 1'b1; pend_due[i] = -1;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", int'(vld[0]), 0);
        chk("rst_busy", int'(bsy[0]), 0);
        chk("rst_data", int'(rxd[1]), 0);
        chk("rst_flags", int'({pe[1], fe[1], ov[1]}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(5);

        // 8N1, 0xA5: clean frame, 156-cycle latency
        send_frame(0, 8'hA5, 0, 1, 1, -1, 0);
        step(2);
        chk("n1_data", got_d[0], 8'hA5);
        chk("n1_flags", got_p[0] * 2 + got_f[0], 0);
        chk("n1_latency", rise_cyc[0] - start_cyc[0], 156);

        // 8O1, 0x3C with correct then wrong parity bit
        send_frame(1, 8'h3C, 1, 1, 1, -1, 0);
        step(2);
        chk("o1_good_data", got_d[1], 8'h3C);
        chk("o1_good_perr", got_p[1], 0);
        send_frame(1, 8'h3C, 0, 1, 1, -1, 0);
        step(2);
        chk("o1_bad_data", got_d[1], 8'h3C);
        chk("o1_bad_perr", got_p[1], 1);
        chk("o1_latency", rise_cyc[1] - start_cyc[1], 172);

        // 8N2, 0x55 with the second stop bit low
        send_frame(2, 8'h55, 0, 1, 0, -1, 0);
        step(2);
        chk("n2_data", got_d[2], 8'h55);
        chk("n2_ferr", got_f[2], 1);

        // Overrun: consumer stalled across two frames
        rdy[0] = 1'b0;
        f0 = frames[0];
        send_frame(0, 8'h11, 0, 1, 1, -1, 0);
        send_frame(0, 8'h22, 0, 1, 1, -1, 0);
        step(4);
        chk("ovr_held", int'(rxd[0]), 8'h11);
        chk("ovr_pulses", ovr_seen[0], 1);
        rdy[0] = 1'b1;
        @(negedge clk);
        chk("ovr_valid_before", int'(vld[0]), 1);
        @(negedge clk);
        chk("ovr_valid_after", int'(vld[0]), 0);
        chk("ovr_frames", frames[0] - f0, 1);
        chk("ovr_got", got_d[0], 8'h11);

        // False start: 4-cycle low glitch
        f0 = frames[0];
        @(posedge clk); #1;
        ser[0] = 1'b0;
        step(4);
        ser[0] = 1'b1;
        step(30);
        chk("glitch_busy", int'(bsy[0]), 0);
        chk("glitch_frames", frames[0] - f0, 0);

        // Break: line held low, exactly one frame with frame_err
        f0 = frames[0];
        send_frame(0, 8'h00, 0, 0, 0, -1, 1);
        step(100);
        chk("break_frames", frames[0] - f0, 1);
        chk("break_ferr", got_f[0], 1);
        chk("break_busy", int'(bsy[0]), 0);
        ser[0] = 1'b1;
        step(40);
        chk("break_after", frames[0] - f0, 1);

`ifdef UART_RX_MAJORITY_EN
        // Mid-bit one-cycle glitch in 0xFF is voted out
        send_frame(0, 8'hFF, 0, 1, 1, 3, 0);
        step(2);
        chk("maj_data", got_d[0], 8'hFF);
`endif

        // Reset during data bit 3 of 0x81, then a full 0x81
        @(posedge clk); #1;
        ser[0] = 1'b0;
        step(C);
        ser[0] = 1'b1; step(C);
        ser[0] = 1'b0; step(C);
        ser[0] = 1'b0; step(C);
        ser[0] = 1'b0; step(C / 2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", int'(bsy[0]), 0);
        chk("mid_rst_valid", int'(vld[0]), 0);
        chk("mid_rst_data", int'(rxd[1]), 0);
        chk("mid_rst_data2", int'(rxd[2]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ser[0] = 1'b1;
        step(20);
        f0 = frames[0];
        send_frame(0, 8'h81, 0, 1, 1, -1, 0);
        step(2);
        chk("post_rst_data", got_d[0], 8'h81);
        chk("post_rst_frames", frames[0] - f0, 1);

        step(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
